// File: rtl/rle_stream_packer.sv
// rle_stream_packer
//   Multi-channel run-length encoder. Each accepted pixel word carries NUM_CH
//   8-bit channels; every channel enabled by i_ch_en keeps its own run
//   tracker, restarted at each row boundary. Closed runs are queued in a
//   per-channel FIFO and serialised round-robin as 3-byte records:
//     byte0 = {eor, 3'b000, ch[3:0]}, byte1 = count, byte2 = value.
//
// Ports
//   CLK, RST      clock, asynchronous active-low reset
//   i_pixel       NUM_CH*8 pixel word, channel k = i_pixel[8k+7:8k]
//   i_ch_en       channel k consumes this word when bit k = 1
//   i_valid       pixel word offered
//   o_in_ready    block can take a pixel word
//   o_byte        output byte
//   o_valid       o_byte valid
//   i_out_ready   downstream takes o_byte
//   o_busy        any open run, queued record or record in flight
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready
// are both high (accept = i_valid & o_in_ready, xfer = o_valid & i_out_ready).
// A producer holds its payload and valid stable until the transfer; ready may
// change freely and never depends combinationally on the matching valid.
//
// FSM state is held in ctl_state (row control) and ser_state (serializer).

module rle_stream_packer #(
  parameter int NUM_CH     = 3,
  parameter int ROW_PIXELS = 640,
  parameter int MAX_RUN    = 255,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_CH*8-1:0] i_pixel,
  input  logic [NUM_CH-1:0]   i_ch_en,
  input  logic                i_valid,
  output logic                o_in_ready,
  output logic [7:0]          o_byte,
  output logic                o_valid,
  input  logic                i_out_ready,
  output logic                o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam logic [7:0]    MAX_CNT = 8'(MAX_RUN);
  localparam logic [PW-1:0] LAST_PX = PW'(ROW_PIXELS - 1);
  localparam logic [AW:0]   DEPTH_P = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {C_INIT, C_RUN, C_FLUSH} ctl_state_t;
  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_B2} ser_state_t;

  ctl_state_t ctl_state;
  ser_state_t ser_state;

  // Run trackers and per-channel FIFOs; a FIFO entry is {eor, count, value}.
  logic [7:0]  cur_val  [NUM_CH];
  logic [7:0]  cur_cnt  [NUM_CH];
  logic [16:0] fifo_mem [NUM_CH][FIFO_DEPTH];
  logic [AW:0] wr_ptr   [NUM_CH];
  logic [AW:0] rd_ptr   [NUM_CH];
  logic [16:0] push_rec [NUM_CH];

  logic [NUM_CH-1:0] fifo_full, fifo_nempty, run_open, push, pop;
  logic [PW-1:0]     px_cnt;
  logic              any_full, any_ne, accept, flush_go, pop_en;
  logic [CW-1:0]     last_served, winner;
  logic [16:0]       rec;
  logic [7:0]        rec_cnt, rec_val;
  int                best_d, d;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      fifo_full[k]   = (wr_ptr[k] - rd_ptr[k]) == DEPTH_P;
      fifo_nempty[k] = wr_ptr[k] != rd_ptr[k];
      run_open[k]    = cur_cnt[k] != 8'd0;
    end
  end

  assign any_full   = |fifo_full;
  assign any_ne     = |fifo_nempty;
  // Every FIFO needs a free slot so any channel may close a run on accept.
  assign o_in_ready = (ctl_state == C_RUN) && !any_full;
  assign accept     = i_valid && o_in_ready;
  assign flush_go   = (ctl_state == C_FLUSH) && !any_full;
  assign o_busy     = (|run_open) || any_ne || (ser_state != S_IDLE);

  // Run closure: a flush closes every open run with eor set; an accept closes
  // a run when the value changes or the run is saturated.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      push[k]     = 1'b0;
      push_rec[k] = {1'b0, cur_cnt[k], cur_val[k]};
      if (flush_go) begin
        push[k]         = run_open[k];
        push_rec[k][16] = 1'b1;
      end else if (accept && i_ch_en[k] && run_open[k] &&
                   ((i_pixel[8*k +: 8] != cur_val[k]) || (cur_cnt[k] == MAX_CNT))) begin
        push[k] = 1'b1;
      end
    end
  end

  // Round robin: the non-empty channel closest after last_served wins.
  always_comb begin
    winner = last_served;
    best_d = NUM_CH;
    d      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      d = k - int'(last_served) - 1;
      if (d < 0) d = d + NUM_CH;
      if (fifo_nempty[k] && (d < best_d)) begin
        best_d = d;
        winner = CW'(k);
      end
    end
  end

  always_comb begin
    rec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (winner == CW'(k)) rec = fifo_mem[k][rd_ptr[k][AW-1:0]];
    end
  end

  // A new record is loaded when idle, or on the final byte's transfer so the
  // next record follows without a bubble.
  assign pop_en = (ser_state == S_IDLE) || ((ser_state == S_B2) && i_out_ready);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      pop[k] = pop_en && any_ne && (winner == CW'(k));
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) fifo_mem[k][wr_ptr[k][AW-1:0]] <= push_rec[k];
    end
  end

  // Row control, run trackers and FIFO pointers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ctl_state <= C_INIT;
      px_cnt    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cur_val[k] <= 8'd0;
        cur_cnt[k] <= 8'd0;
        wr_ptr[k]  <= '0;
        rd_ptr[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + (AW+1)'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + (AW+1)'(1);
        if (flush_go) begin
          cur_cnt[k] <= 8'd0;
        end else if (accept && i_ch_en[k]) begin
          if (run_open[k] && (i_pixel[8*k +: 8] == cur_val[k]) && (cur_cnt[k] != MAX_CNT)) begin
            cur_cnt[k] <= cur_cnt[k] + 8'd1;
          end else begin
            cur_val[k] <= i_pixel[8*k +: 8];
            cur_cnt[k] <= 8'd1;
          end
        end
      end
      case (ctl_state)
        C_INIT: ctl_state <= C_RUN;
        C_RUN: begin
          if (accept) begin
            if (px_cnt == LAST_PX) begin
              px_cnt    <= '0;
              ctl_state <= C_FLUSH;
            end else begin
              px_cnt <= px_cnt + PW'(1);
            end
          end
        end
        C_FLUSH: if (flush_go) ctl_state <= C_RUN;
        default: ctl_state <= C_RUN;
      endcase
    end
  end

  // Serializer with registered byte and valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_state   <= S_IDLE;
      o_valid     <= 1'b0;
      o_byte      <= 8'd0;
      rec_cnt     <= 8'd0;
      rec_val     <= 8'd0;
      last_served <= CW'(NUM_CH - 1);
    end else begin
      if (pop_en && any_ne) begin
        o_byte      <= {rec[16], 3'b000, 4'(winner)};
        rec_cnt     <= rec[15:8];
        rec_val     <= rec[7:0];
        last_served <= winner;
        o_valid     <= 1'b1;
        ser_state   <= S_B0;
      end else begin
        case (ser_state)
          S_IDLE: ;
          S_B0: if (i_out_ready) begin
            o_byte    <= rec_cnt;
            ser_state <= S_B1;
          end
          S_B1: if (i_out_ready) begin
            o_byte    <= rec_val;
            ser_state <= S_B2;
          end
          S_B2: if (i_out_ready) begin
            o_byte    <= 8'd0;
            o_valid   <= 1'b0;
            ser_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rle_stream_packer.sv
// Bench for rle_stream_packer (NUM_CH=3, ROW_PIXELS=640, MAX_RUN=255).
// A pixel-queue reference model produces expected records per channel; a
// monitor decodes the byte stream and pops/compares against those queues.
module tb_rle_stream_packer;
  localparam int NCH  = 3;
  localparam int ROW  = 640;
  localparam int MAXR = 255;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [23:0] i_pixel = '0;
  logic [2:0]  i_ch_en = '0;
  logic        i_valid = 1'b0;
  logic        o_in_ready;
  logic [7:0]  o_byte;
  logic        o_valid;
  logic        i_out_ready = 1'b1;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled, 3 manual
  int pix_cnt = 0;
  bit seen_low = 1'b0;

  logic [23:0] exp_q [NCH][$];
  logic [7:0]  pend  [NCH][$];
  int          got_ch[$];
  int          byte_cyc[$];

  rle_stream_packer dut (
    .CLK(CLK), .RST(RST), .i_pixel(i_pixel), .i_ch_en(i_ch_en),
    .i_valid(i_valid), .o_in_ready(o_in_ready), .o_byte(o_byte),
    .o_valid(o_valid), .i_out_ready(i_out_ready), .o_busy(o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial forever begin
    @(posedge CLK);
    #1;
    case (rdy_mode)
      0: i_out_ready = 1'b1;
      1: i_out_ready = ($urandom_range(0, 3) != 0);
      2: i_out_ready = 1'b0;
      default: ;
    endcase
  end

  initial forever begin
    @(negedge CLK);
    if (rdy_mode == 2 && RST && !o_in_ready) seen_low = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] mk_rec(int ch, bit eor, int cnt, logic [7:0] v);
    logic [7:0] b0;
    b0 = 8'(ch);
    b0[7] = eor;
    return {b0, 8'(cnt), v};
  endfunction

  // Each channel holds the pixels of its not-yet-emitted run; a record is the
  // length of that list and its value.
  task automatic model_accept(input logic [23:0] px, input logic [2:0] en);
    logic [7:0] v;
    for (int c = 0; c < NCH; c++) begin
      if (en[c]) begin
        v = px[8*c +: 8];
        if (pend[c].size() > 0 && (v != pend[c][0] || pend[c].size() == MAXR)) begin
          exp_q[c].push_back(mk_rec(c, 1'b0, pend[c].size(), pend[c][0]));
          pend[c].delete();
        end
        pend[c].push_back(v);
      end
    end
    pix_cnt++;
    if (pix_cnt == ROW) begin
      for (int c = 0; c < NCH; c++) begin
        if (pend[c].size() > 0) exp_q[c].push_back(mk_rec(c, 1'b1, pend[c].size(), pend[c][0]));
        pend[c].delete();
      end
      pix_cnt = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_px(input logic [23:0] px, input logic [2:0] en);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    i_pixel = px;
    i_ch_en = en;
    i_valid = 1'b1;
    while (!done && waited <= 4000) begin
      @(negedge CLK);
      if (o_in_ready) begin
        @(posedge CLK);
        done = 1'b1;
      end else begin
        @(posedge CLK);
        waited++;
      end
    end
    if (done) model_accept(px, en);
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
    #1 i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge CLK);
    while (o_busy && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    check("drain_busy", o_busy, 0);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] rnd_px(int hi);
    return {8'($urandom_range(0, hi)), 8'($urandom_range(0, hi)), 8'($urandom_range(0, hi))};
  endfunction

  // kind 0: short random runs; kind 1: long sticky runs
  task automatic finish_row(input int kind);
    logic [23:0] cur;
    int guard;
    cur = rnd_px(255);
    guard = 0;
    do begin
      if (kind == 0) cur = rnd_px(2);
      else if ($urandom_range(0, 15) == 0) cur = rnd_px(255);
      send_px(cur, 3'($urandom_range(0, 7)));
      guard++;
    end while (pix_cnt != 0 && guard < ROW + 10);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [7:0] rb0, rb1;
    logic [7:0] prev_byte;
    bit prev_stall;
    int bidx, ch;
    bidx = 0;
    prev_stall = 1'b0;
    prev_byte = '0;
    rb0 = '0;
    rb1 = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        bidx = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", o_valid, 1);
          check("hold_byte", o_byte, prev_byte);
        end
        if (o_valid && i_out_ready) begin
          byte_cyc.push_back(cyc);
          if (bidx == 0) rb0 = o_byte;
          else if (bidx == 1) rb1 = o_byte;
          else begin
            ch = int'(rb0[3:0]);
            got_ch.push_back(ch);
            if (ch >= NCH || exp_q[ch].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL record_unexpected actual=%h%h%h required=none", rb0, rb1, o_byte);
            end else begin
              check("record", {rb0, rb1, o_byte}, exp_q[ch].pop_front());
            end
          end
          bidx = (bidx == 2) ? 0 : bidx + 1;
        end
        prev_stall = o_valid && !i_out_ready;
        prev_byte = o_byte;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_in_ready", o_in_ready, 0);
    check("rst_o_byte", o_byte, 0);
    check("rst_o_busy", o_busy, 0);
    @(posedge CLK);
    #1 RST = 1'b1;

    // Constant RGB row: saturated runs, channel order 0,1,2 rotating.
    repeat (ROW) send_px({8'd30, 8'd20, 8'd10}, 3'b111);
    wait_drain();
    check("t1_nrec", got_ch.size(), 9);
    for (int i = 0; i < got_ch.size() && i < 9; i++) check("t1_order", got_ch[i], i % 3);

    // Latency: run closing in accept cycle N shows byte0 in cycle N+2.
    send_px(24'h070000, 3'b100);
    idle(3);
    send_px(24'h080000, 3'b100);
    check("lat_early_valid", o_valid, 0);
    @(posedge CLK);
    #1;
    check("lat_valid", o_valid, 1);
    check("lat_byte0", o_byte, 8'h02);
    idle(8);

    // Three simultaneous closures with the pointer at ch1.
    send_px(24'h000100, 3'b010);
    send_px(24'h000200, 3'b010);
    idle(12);
    got_ch.delete();
    byte_cyc.delete();
    send_px(24'h000005, 3'b001);
    send_px({8'd6, 8'd3, 8'd6}, 3'b111);
    n = 0;
    while (got_ch.size() < 3 && n < 60) begin
      @(posedge CLK);
      n++;
    end
    #1;
    if (got_ch.size() < 3) begin
      checks++;
      errors++;
      $display("FAIL t5_timeout actual=%0d required=3", got_ch.size());
    end else begin
      check("t5_first", got_ch[0], 2);
      check("t5_second", got_ch[1], 0);
      check("t5_third", got_ch[2], 1);
      check("t5_no_bubble", byte_cyc[8] - byte_cyc[0], 8);
    end
    rdy_mode = 1;
    finish_row(0);
    wait_drain();
    rdy_mode = 0;

    // YUV422: Y every pixel, U even, V odd.
    for (int i = 0; i < ROW; i++) send_px({8'd30, 8'd20, 8'd10}, (i % 2 == 0) ? 3'b011 : 3'b101);
    wait_drain();

    // Long downstream stall mid-row.
    seen_low = 1'b0;
    fork
      begin
        repeat (60) @(posedge CLK);
        #1 rdy_mode = 2;
        repeat (200) @(posedge CLK);
        #1 rdy_mode = 0;
      end
    join_none
    repeat (ROW) send_px(rnd_px(1), 3'b111);
    wait_drain();
    check("t4_ready_dropped", seen_low, 1);

    // Random rows with random backpressure.
    rdy_mode = 1;
    finish_row(0);
    wait_drain();
    finish_row(1);
    wait_drain();

    // Reset while the serializer sits in B1.
    rdy_mode = 3;
    i_out_ready = 1'b0;
    send_px(24'h000001, 3'b001);
    send_px(24'h000002, 3'b001);
    n = 0;
    @(negedge CLK);
    while (!o_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("t6_valid", o_valid, 1);
    @(posedge CLK);
    #1 i_out_ready = 1'b1;
    @(posedge CLK);
    #1 i_out_ready = 1'b0;
    @(negedge CLK);
    check("t6_in_b1_count", o_byte, 1);
    #1 RST = 1'b0;
    #1;
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_in_ready", o_in_ready, 0);
    check("t6_rst_byte", o_byte, 0);
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      pend[c].delete();
    end
    pix_cnt = 0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    rdy_mode = 1;
    finish_row(1);
    wait_drain();

    idle(5);
    for (int c = 0; c < NCH; c++) check("leftover_records", exp_q[c].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
